// File: rtl/vga_scan_out_pkg.sv
// ---------------------------------------------------------------------------
// vga_scan_out_pkg
//   Shared definitions for the VGA scan-out path:
//   - default 640x480@60 timing constants (pixels / lines)
//   - counter width and counter type used by the raster counters
//   - RGB332 colour byte layout, shared with the colour mapper
//   - a small window-decode helper used for the sync pulses
// ---------------------------------------------------------------------------
package vga_scan_out_pkg;

  // Raster counters are wide enough for H_TOTAL-1 (799) and V_TOTAL-1 (524).
  localparam int CNT_W = 10;

  localparam int CLK_DIV_DEF   = 2;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // RGB332 field positions inside the colour byte {R[2:0],G[2:0],B[1:0]}.
  localparam int RED_MSB = 7;
  localparam int RED_LSB = 5;
  localparam int GRN_MSB = 4;
  localparam int GRN_LSB = 2;
  localparam int BLU_MSB = 1;
  localparam int BLU_LSB = 0;

  typedef struct packed {
    logic [RED_MSB-RED_LSB:0] red;
    logic [GRN_MSB-GRN_LSB:0] green;
    logic [BLU_MSB-BLU_LSB:0] blue;
  } rgb332_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= cnt < hi.
  function automatic logic in_window(input cnt_t cnt, input cnt_t lo, input cnt_t hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// ---------------------------------------------------------------------------
// vga_pixel_div
//   Divides the system clock down to the pixel rate. A free-running counter
//   runs 0..CLK_DIV-1 and pix_tick_o is high in its last state, giving one
//   single-clock strobe per pixel period. With CLK_DIV=1 the strobe is held
//   high. The strobe is forced low while reset is asserted.
// Ports
//   clk         in  system clock
//   rst_n       in  asynchronous reset, active-low
//   pix_tick_o  out one-clock pixel strobe
// ---------------------------------------------------------------------------
module vga_pixel_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Gated with rst_n so CLK_DIV=1 still shows no strobe during reset.
  assign pix_tick_o = rst_n & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_scan_out.sv
// ---------------------------------------------------------------------------
// vga_scan_out
//   Raster timing generator and output register for a VGA connector.
//   Publishes the current raster coordinate so upstream logic can return a
//   colour byte combinationally, then registers that byte (blanked outside
//   the visible area) together with the active-low syncs on each pixel
//   strobe, so colour and syncs are mutually aligned one pixel after the
//   coordinate. Also emits a one-clock pulse when the raster wraps to (0,0).
// Ports
//   clk          in  system clock
//   rst_n        in  asynchronous reset, active-low
//   rgb_in       in  RGB332 colour for (pix_x,pix_y)
//   pix_x/pix_y  out current horizontal / vertical count
//   pix_valid    out coordinate lies in the visible area
//   pix_tick     out pixel strobe; counters and outputs update on it
//   frame_start  out one-clock pulse after the wrap to (0,0)
//   hsync/vsync  out active-low syncs
//   vga_red/green/blue out registered colour
// ---------------------------------------------------------------------------
module vga_scan_out
  import vga_scan_out_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rgb_in,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_valid,
  output logic             pix_tick,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [2:0]       vga_red,
  output logic [2:0]       vga_green,
  output logic [1:0]       vga_blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = CNT_W'(H_VISIBLE);
  localparam cnt_t V_VIS    = CNT_W'(V_VISIBLE);
  localparam cnt_t HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic    tick;
  cnt_t    h_cnt_q, h_cnt_d;
  cnt_t    v_cnt_q, v_cnt_d;
  logic    visible;
  logic    frame_wrap;
  rgb332_t rgb_q, rgb_d;
  logic    hsync_q, vsync_q, frame_start_q;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_tick_o (tick)
  );

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  assign visible    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_wrap = tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign rgb_d      = visible ? rgb332_t'(rgb_in) : '0;

  // Output stage samples the pre-increment coordinate, so colour and syncs
  // trail the published coordinate by exactly one pixel period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_wrap;
      if (tick) begin
        rgb_q   <= rgb_d;
        hsync_q <= ~in_window(h_cnt_q, HS_START, HS_END);
        vsync_q <= ~in_window(v_cnt_q, VS_START, VS_END);
      end
    end
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign pix_valid   = visible;
  assign pix_tick    = tick;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_red     = rgb_q.red;
  assign vga_green   = rgb_q.green;
  assign vga_blue    = rgb_q.blue;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out. Horizontal timing is the full 640x480 line; the
// vertical frame is shortened to 9 lines so several frames fit in a short run.
module tb_vga_scan_out;

  localparam int D  = 2;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 4,   VF = 1,  VS = 2,  VB = 2;
  localparam int HT = HV + HF + HS + HB;   // 800
  localparam int VT = VV + VF + VS + VB;   // 9
  localparam int FRAME_CLK = HT * VT * D;  // 14400

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rgb_in;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid, pix_tick, frame_start, hsync, vsync;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;

  vga_scan_out #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_tick(pix_tick),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  function automatic logic [7:0] pat(input int m, input int x, input int y);
    if (m == 0) return 8'hFF;
    if (m == 1) return 8'(x);
    return 8'(x + 3 * y) ^ 8'h5A;
  endfunction

  // Upstream renderer: returns a colour for the published coordinate.
  always @* begin
    rgb_in = pat(mode, int'(pix_x), int'(pix_y));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: everything follows from c, the number of clock edges
  // seen since reset release, and the frame geometry.
  int   c = 0;
  int   abs_pos = 0;
  logic pos_live = 1'b0;
  int   run = 0;
  logic [7:0] e_rgb;
  logic e_hs, e_vs, e_fs;
  event mon_ev;

  int ff_cnt = 0, first_ff = -1, hs_low = 0, first_hs_low = -1, vs_low = 0;
  int fs_abs[$];
  int fs_c[$];

  always @(posedge clk) begin
    pos_live = rst_n;
    abs_pos++;
  end

  always @(negedge clk) begin : mon
    int k, ex, ey, q, qx, qy;
    logic e_tick, e_valid;
    logic [7:0] dut_rgb;
    if (!rst_n) begin
      c = 0; e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    end else begin
      if (pos_live) c++;
      e_fs = 1'b0;
      if (c > 0 && c % D == 0) begin
        q  = c / D - 1;
        qx = q % HT;
        qy = (q / HT) % VT;
        e_rgb = (qx < HV && qy < VV) ? pat(mode, qx, qy) : 8'h00;
        e_hs  = !(qx >= HV + HF && qx < HV + HF + HS);
        e_vs  = !(qy >= VV + VF && qy < VV + VF + VS);
        e_fs  = (q % (HT * VT)) == HT * VT - 1;
      end
    end
    k  = c / D;
    ex = k % HT;
    ey = (k / HT) % VT;
    e_tick  = rst_n && (c % D == D - 1);
    e_valid = ex < HV && ey < VV;
    dut_rgb = {vga_red, vga_green, vga_blue};
    chk("pix_x", 32'(pix_x), 32'(ex));
    chk("pix_y", 32'(pix_y), 32'(ey));
    chk("pix_valid", 32'(pix_valid), 32'(e_valid));
    chk("pix_tick", 32'(pix_tick), 32'(e_tick));
    chk("rgb", 32'(dut_rgb), 32'(e_rgb));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    if (rst_n && run == 0) begin
      if (c < 2 * HT + 2) begin
        if (dut_rgb == 8'hFF) begin
          ff_cnt++;
          if (first_ff < 0) first_ff = c;
        end
        if (hsync == 1'b0) begin
          hs_low++;
          if (first_hs_low < 0) first_hs_low = c;
        end
      end
      if (c < FRAME_CLK + 2 && vsync == 1'b0) vs_low++;
    end
    if (rst_n && frame_start === 1'b1) begin
      fs_abs.push_back(abs_pos);
      fs_c.push_back(c);
    end
    -> mon_ev;
  end

  task automatic wait_c(input int target);
    int guard = 0;
    while (c < target && guard < 30000) begin
      @(mon_ev);
      guard++;
    end
    if (c < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_c timeout got=%0d expected=%0d", c, target);
    end
  endtask

  initial begin
    int rel_abs;
    rst_n = 1'b0;
    repeat (4) @(mon_ev);
    // Reset state
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("rst_tick", 32'(pix_tick), 32'd0);
    #1 rst_n = 1'b1;

    // Strobe on every second clock after release
    for (int i = 1; i <= 6; i++) begin
      @(mon_ev);
      chk("tick_phase", 32'(pix_tick), 32'(i % 2));
    end

    // One line of white, and the hsync pulse position and width
    wait_c(2 * HT + 2);
    chk("line_ff_clks", 32'(ff_cnt), 32'd1280);
    chk("first_ff_clk", 32'(first_ff), 32'd2);
    chk("hsync_low_clks", 32'(hs_low), 32'd192);
    chk("hsync_fall_clk", 32'(first_hs_low), 32'd1314);

    wait_c(1700);
    #1 mode = 1;
    wait_c(2202);   // pixel (300,1) registered
    chk("lit_rgb_x300", 32'({vga_red, vga_green, vga_blue}), 32'h2C);
    wait_c(3002);   // pixel (700,1) registered, blanked
    chk("lit_rgb_x700", 32'({vga_red, vga_green, vga_blue}), 32'h00);
    chk("lit_pix_x701", 32'(pix_x), 32'd701);

    // vsync width and first frame strobe
    wait_c(FRAME_CLK + 2);
    chk("vsync_low_clks", 32'(vs_low), 32'd3200);
    chk("fs_count1", 32'(fs_abs.size()), 32'd1);
    if (fs_c.size() >= 1) chk("fs_first_c", 32'(fs_c[0]), 32'd14400);

    wait_c(20000);
    #1 mode = 2;
    wait_c(2 * FRAME_CLK + 2);
    chk("fs_count2", 32'(fs_abs.size()), 32'd2);
    if (fs_abs.size() >= 2) chk("fs_spacing", 32'(fs_abs[1] - fs_abs[0]), 32'd14400);

    // Reset in the middle of a frame at pixel (300,2)
    wait_c(32600);
    chk("pre_rst_x", 32'(pix_x), 32'd300);
    chk("pre_rst_y", 32'(pix_y), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    chk("mid_rst_rgb", 32'({vga_red, vga_green, vga_blue}), 32'd0);
    chk("mid_rst_xy", 32'({pix_x, pix_y}), 32'd0);
    chk("mid_rst_tick", 32'(pix_tick), 32'd0);
    repeat (3) @(mon_ev);
    #1 rst_n = 1'b1;
    rel_abs = abs_pos;
    run = 1;
    wait_c(FRAME_CLK + 2);
    chk("fs_count3", 32'(fs_abs.size()), 32'd3);
    if (fs_abs.size() >= 3) chk("fs_after_rst", 32'(fs_abs[2] - rel_abs), 32'd14400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
